// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register and ALU operand select.
//
// Holds one decoded instruction behind a valid/ready handshake. It supports
// stall (outValid & !outReady) and flush, and resolves RAW hazards by
// forwarding from EX/MEM and MEM/WB.
//
// Optional feature macro: EX_FORWARD_EN
//   defined     : forwarding on held rs1/rs2 (EX/MEM beats MEM/WB), plus
//                 refresh of the held operands while stalled
//   not defined : forwarding ports are ignored, so the hazard unit must stall
//
// Ports
//   clk, rstN                      clock, synchronous active-low reset
//   inValid/inReady                upstream handshake
//   rs1Data, rs2Data, imm, pc      operand sources
//   rs1Addr, rs2Addr, rdAddrIn     register indices
//   aluCtrlIn, srcASel, srcBSel    ALU op and operand selects
//   regWrIn                        instruction writes rd
//   flush                          kill held and incoming instruction
//   outValid/outReady              downstream handshake
//   in0, in1, aluCtrl              ALU inputs
//   rdAddr, regWr, storeData       destination, write enable, store value
//   exMemRd/RegWr/Res, memWbRd/RegWr/Res   forwarding sources

// Per-operand forwarding mux. EX/MEM is younger than MEM/WB, so it wins.
module id_ex_fwd #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] ra,
  input  logic [XLEN-1:0] held,
  input  logic [RA_W-1:0] exMemRd,
  input  logic            exMemRegWr,
  input  logic [XLEN-1:0] exMemRes,
  input  logic [RA_W-1:0] memWbRd,
  input  logic            memWbRegWr,
  input  logic [XLEN-1:0] memWbRes,
  output logic [XLEN-1:0] fwd
);
  logic hit_ex, hit_wb;
  assign hit_ex = exMemRegWr & (exMemRd != '0) & (exMemRd == ra);
  assign hit_wb = memWbRegWr & (memWbRd != '0) & (memWbRd == ra);
  assign fwd    = hit_ex ? exMemRes : (hit_wb ? memWbRes : held);
endmodule

module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              inValid,
  output logic              inReady,
  input  logic [XLEN-1:0]   rs1Data,
  input  logic [XLEN-1:0]   rs2Data,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc,
  input  logic [RA_W-1:0]   rs1Addr,
  input  logic [RA_W-1:0]   rs2Addr,
  input  logic [RA_W-1:0]   rdAddrIn,
  input  logic [CTRL_W-1:0] aluCtrlIn,
  input  logic              srcASel,
  input  logic              srcBSel,
  input  logic              regWrIn,
  input  logic              flush,
  input  logic              outReady,
  output logic              outValid,
  output logic [XLEN-1:0]   in0,
  output logic [XLEN-1:0]   in1,
  output logic [CTRL_W-1:0] aluCtrl,
  output logic [RA_W-1:0]   rdAddr,
  output logic              regWr,
  output logic [XLEN-1:0]   storeData,
  input  logic [RA_W-1:0]   exMemRd,
  input  logic              exMemRegWr,
  input  logic [XLEN-1:0]   exMemRes,
  input  logic [RA_W-1:0]   memWbRd,
  input  logic              memWbRegWr,
  input  logic [XLEN-1:0]   memWbRes
);
  localparam int STAGES = 1;

  typedef struct packed {
    logic [1:0][XLEN-1:0] rs;   // [0]=rs1 value, [1]=rs2 value
    logic [1:0][RA_W-1:0] ra;   // [0]=rs1 index, [1]=rs2 index
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      pc;
    logic [RA_W-1:0]      rd;
    logic [CTRL_W-1:0]    ctrl;
    logic                 srcA;
    logic                 srcB;
    logic                 wr;
  } ent_t;

  ent_t                 ent;
  logic [STAGES:1]      vld_pipe;
  logic [1:0][XLEN-1:0] fwd;

  assign outValid = vld_pipe[STAGES];
  assign inReady  = ~outValid | outReady;

`ifdef EX_FORWARD_EN
  for (genvar i = 0; i < 2; i++) begin : g_fwd
    id_ex_fwd #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd (
      .ra(ent.ra[i]), .held(ent.rs[i]),
      .exMemRd(exMemRd), .exMemRegWr(exMemRegWr), .exMemRes(exMemRes),
      .memWbRd(memWbRd), .memWbRegWr(memWbRegWr), .memWbRes(memWbRes),
      .fwd(fwd[i])
    );
  end
`else
  assign fwd = ent.rs;
  logic unused_fwd;
  assign unused_fwd = ^{exMemRd, exMemRegWr, exMemRes, memWbRd, memWbRegWr, memWbRes};
`endif

  always_ff @(posedge clk) begin
    if (!rstN) begin
      vld_pipe <= '0;
      ent      <= '0;
    end else if (flush) begin
      // Flush beats load: the incoming instruction is dropped too.
      vld_pipe[1] <= 1'b0;
    end else if (inReady) begin
      vld_pipe[1] <= inValid;
      if (inValid) begin
        ent.rs   <= {rs2Data, rs1Data};
        ent.ra   <= {rs2Addr, rs1Addr};
        ent.imm  <= imm;
        ent.pc   <= pc;
        ent.rd   <= rdAddrIn;
        ent.ctrl <= aluCtrlIn;
        ent.srcA <= srcASel;
        ent.srcB <= srcBSel;
        ent.wr   <= regWrIn & (rdAddrIn != '0);  // x0 is never written
      end
    end
`ifdef EX_FORWARD_EN
    else begin
      // Stalled: latch forwarded values so a result leaving MEM/WB during
      // the stall is not lost.
      ent.rs <= fwd;
    end
`endif
  end

  assign in0       = ent.srcA ? ent.pc  : fwd[0];
  assign in1       = ent.srcB ? ent.imm : fwd[1];
  assign storeData = fwd[1];
  assign aluCtrl   = ent.ctrl;
  assign rdAddr    = ent.rd;
  assign regWr     = ent.wr;
endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rstN, inValid, inReady, srcASel, srcBSel, regWrIn, flush, outReady, outValid, regWr;
  logic [31:0] rs1Data, rs2Data, imm, pc, in0, in1, storeData, exMemRes, memWbRes;
  logic [4:0]  rs1Addr, rs2Addr, rdAddrIn, rdAddr, exMemRd, memWbRd;
  logic [3:0]  aluCtrlIn, aluCtrl;
  logic        exMemRegWr, memWbRegWr;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .imm(imm), .pc(pc),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rdAddrIn(rdAddrIn), .aluCtrlIn(aluCtrlIn),
    .srcASel(srcASel), .srcBSel(srcBSel), .regWrIn(regWrIn), .flush(flush),
    .outReady(outReady), .outValid(outValid), .in0(in0), .in1(in1), .aluCtrl(aluCtrl),
    .rdAddr(rdAddr), .regWr(regWr), .storeData(storeData),
    .exMemRd(exMemRd), .exMemRegWr(exMemRegWr), .exMemRes(exMemRes),
    .memWbRd(memWbRd), .memWbRegWr(memWbRegWr), .memWbRes(memWbRes)
  );

  typedef struct {
    logic [31:0] in0, in1, sd;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        wr;
  } exp_t;

  // Reference model of the held instruction.
  typedef struct {
    bit          v;
    logic [31:0] r1, r2, imm, pc;
    logic [4:0]  a1, a2, rd;
    logic [3:0]  ctrl;
    bit          sa, sb, wr;
  } mst_t;

  exp_t q[$];
  mst_t st;
  int   nvec = 0, nmis = 0;
  bit   exp_valid, exp_inready;

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Value a consumer of register a should see: newest in-flight producer wins.
  function automatic logic [31:0] src(input logic [4:0] a, input logic [31:0] held);
    if (FWD && exMemRegWr && exMemRd != 0 && exMemRd == a) return exMemRes;
    if (FWD && memWbRegWr && memWbRd != 0 && memWbRd == a) return memWbRes;
    return held;
  endfunction

  task automatic model_edge();
    if (!rstN) st = '{default: 0};
    else if (flush) st.v = 0;
    else if (!st.v || outReady) begin
      st.v = inValid;
      if (inValid) begin
        st.r1 = rs1Data; st.r2 = rs2Data; st.imm = imm; st.pc = pc;
        st.a1 = rs1Addr; st.a2 = rs2Addr; st.rd = rdAddrIn; st.ctrl = aluCtrlIn;
        st.sa = srcASel; st.sb = srcBSel; st.wr = regWrIn && rdAddrIn != 0;
      end
    end else if (FWD) begin
      st.r1 = src(st.a1, st.r1);
      st.r2 = src(st.a2, st.r2);
    end
  endtask

  // One cycle with the inputs currently driven: publish expectations,
  // advance the model at the edge, return 1 time unit after the edge.
  task automatic tick();
    exp_t e;
    exp_valid   = st.v;
    exp_inready = !st.v || outReady;
    if (rstN && st.v && outReady) begin
      e.in0  = st.sa ? st.pc : src(st.a1, st.r1);
      e.sd   = src(st.a2, st.r2);
      e.in1  = st.sb ? st.imm : e.sd;
      e.ctrl = st.ctrl; e.rd = st.rd; e.wr = st.wr;
      q.push_back(e);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    inValid = 0; flush = 0; outReady = 1; regWrIn = 0;
    rs1Data = 0; rs2Data = 0; imm = 0; pc = 0; rs1Addr = 0; rs2Addr = 0; rdAddrIn = 0;
    aluCtrlIn = 0; srcASel = 0; srcBSel = 0;
    exMemRd = 0; exMemRegWr = 0; exMemRes = 0; memWbRd = 0; memWbRegWr = 0; memWbRes = 0;
  endtask

  task automatic rand_in();
    rs1Data = $urandom; rs2Data = $urandom; imm = $urandom; pc = $urandom;
    rs1Addr = 5'($urandom_range(0, 3)); rs2Addr = 5'($urandom_range(0, 3));
    rdAddrIn = 5'($urandom_range(0, 3)); aluCtrlIn = 4'($urandom_range(0, 15));
    srcASel = 1'($urandom_range(0, 1)); srcBSel = 1'($urandom_range(0, 1));
    regWrIn = 1'($urandom_range(0, 1));
    inValid = ($urandom_range(0, 9) < 7); outReady = ($urandom_range(0, 9) < 6);
    flush = ($urandom_range(0, 9) == 0);
    exMemRd = 5'($urandom_range(0, 3)); exMemRegWr = 1'($urandom_range(0, 1)); exMemRes = $urandom;
    memWbRd = 5'($urandom_range(0, 3)); memWbRegWr = 1'($urandom_range(0, 1)); memWbRes = $urandom;
    rstN = ($urandom_range(0, 99) != 0);
  endtask

  // Monitor: checks handshake state every cycle and pops the scoreboard on
  // every completed output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rstN === 1'b1) begin
      chk("outValid", {31'b0, outValid}, {31'b0, exp_valid});
      chk("inReady", {31'b0, inReady}, {31'b0, exp_inready});
      if (outValid && outReady) begin
        if (q.size() == 0) begin
          nvec++; nmis++;
          $display("FAIL unexpected_output: got outValid=1 expected no pending item at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("in0", in0, e.in0);
          chk("in1", in1, e.in1);
          chk("storeData", storeData, e.sd);
          chk("aluCtrl", {28'b0, aluCtrl}, {28'b0, e.ctrl});
          chk("rdAddr", {27'b0, rdAddr}, {27'b0, e.rd});
          chk("regWr", {31'b0, regWr}, {31'b0, e.wr});
        end
      end
    end
  end

  initial begin
    st = '{default: 0};
    idle();
    rstN = 0;
    tick(); tick();
    rstN = 1;
    chk("reset_aluCtrl", {28'b0, aluCtrl}, 32'd0);
    chk("reset_regWr", {31'b0, regWr}, 32'd0);
    chk("reset_outValid", {31'b0, outValid}, 32'd0);
    chk("reset_inReady", {31'b0, inReady}, 32'd1);
    tick();

    // Pass-through with immediate.
    inValid = 1; rs1Data = 5; imm = 7; srcBSel = 1; aluCtrlIn = 0;
    tick();
    idle();
    chk("pass_in0", in0, 32'd5);
    chk("pass_in1", in1, 32'd7);
    tick();

    // Forward priority: both match, EX/MEM disabled, rd=0.
    for (int k = 0; k < 3; k++) begin
      idle();
      inValid = 1; rs1Addr = 3; rs1Data = 32'h11;
      tick();
      idle();
      exMemRd = (k == 2) ? 5'd0 : 5'd3; exMemRegWr = (k != 1); exMemRes = 32'hAA;
      memWbRd = (k == 2) ? 5'd0 : 5'd3; memWbRegWr = 1; memWbRes = 32'hBB;
      #1;
      chk("fwd_in0", in0, !FWD ? 32'h11 : (k == 0) ? 32'hAA : (k == 1) ? 32'hBB : 32'h11);
      tick();
    end

    // Stall refresh: MEM/WB retires rs2's producer mid-stall.
    idle();
    inValid = 1; rs2Addr = 2; rs2Data = 32'h55;
    tick();
    idle(); outReady = 0;
    tick();
    memWbRd = 2; memWbRegWr = 1; memWbRes = 32'h1234; outReady = 0;
    tick();
    memWbRegWr = 0;
    chk("stall_inReady", {31'b0, inReady}, 32'd0);
    tick();
    outReady = 1;
    #1;
    chk("stall_storeData", storeData, FWD ? 32'h1234 : 32'h55);
    tick();

    // Flush beats a same-cycle load.
    idle();
    inValid = 1; rs1Data = 32'h77;
    tick();
    inValid = 1; flush = 1; rs1Data = 32'h99;
    tick();
    idle();
    chk("flush_outValid", {31'b0, outValid}, 32'd0);
    tick();

    // x0 destination is never written.
    inValid = 1; rdAddrIn = 0; regWrIn = 1;
    tick();
    idle();
    chk("x0_regWr", {31'b0, regWr}, 32'd0);
    tick();

    // Randomized traffic checked by the scoreboard.
    for (int n = 0; n < 3000; n++) begin
      rand_in();
      tick();
    end

    idle(); rstN = 1;
    repeat (3) tick();
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
